// File: rtl/cmp_run_if.sv
// Sample/result bundle between the magnitude comparator stream and cmp_run_monitor.
// The err signal exists only when CMP_ONEHOT_CHECK_EN is defined.
interface cmp_run_if #(
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             eq;
  logic             gr;
  logic             le;
  logic             stable;
  logic [1:0]       rel;
  logic [CNT_W-1:0] run_len;
  logic             change;
`ifdef CMP_ONEHOT_CHECK_EN
  logic             err;

  modport master (output in_valid, eq, gr, le,
                  input  stable, rel, run_len, change, err);
  modport slave  (input  in_valid, eq, gr, le,
                  output stable, rel, run_len, change, err);
`else
  modport master (output in_valid, eq, gr, le,
                  input  stable, rel, run_len, change);
  modport slave  (input  in_valid, eq, gr, le,
                  output stable, rel, run_len, change);
`endif
endinterface

// File: rtl/cmp_run_monitor.sv
// Run-length monitor for comparator eq/gr/le flags; confirms a relation after STABLE_N matches.
// Optional one-hot flag checking with sticky err is enabled by defining CMP_ONEHOT_CHECK_EN.
module cmp_run_monitor #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned STABLE_N = 3
) (
  input  logic      clk,
  input  logic      rst,
  cmp_run_if.slave  bus
);
  localparam logic [1:0]       REL_NONE   = 2'b00;
  localparam logic [1:0]       REL_LT     = 2'b01;
  localparam logic [1:0]       REL_EQ     = 2'b10;
  localparam logic [1:0]       REL_GT     = 2'b11;
  localparam logic [CNT_W-1:0] RUN_MAX    = '1;
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_N);

  typedef enum logic [1:0] {IDLE, ACQ, STABLE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_code_q, last_code_d;
  logic [1:0]       rel_q, rel_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             change_q, change_d;
  logic             stable_q, stable_d;
  logic [1:0]       code_c;
  logic             ok_c;
  logic             match_c;

  // Flag decode: one-hot enforced when checking is on, else priority eq > gr > le
  always_comb begin
    code_c = REL_LT;
    ok_c   = 1'b1;
`ifdef CMP_ONEHOT_CHECK_EN
    ok_c = ({bus.eq, bus.gr, bus.le} == 3'b100) ||
           ({bus.eq, bus.gr, bus.le} == 3'b010) ||
           ({bus.eq, bus.gr, bus.le} == 3'b001);
`endif
    if (bus.eq)      code_c = REL_EQ;
    else if (bus.gr) code_c = REL_GT;
    else if (bus.le) code_c = REL_LT;
    else             code_c = REL_LT;
  end

  // Run tracking and IDLE/ACQ/STABLE transitions for an accepted sample
  always_comb begin
    state_d     = state_q;
    last_code_d = last_code_q;
    run_d       = run_q;
    rel_d       = rel_q;
    change_d    = 1'b0;
    match_c     = 1'b0;
    if (bus.in_valid && ok_c) begin
      match_c = (state_q != IDLE) && (code_c == last_code_q);
      if (match_c) begin
        if (run_q != RUN_MAX) run_d = run_q + CNT_W'(1);
      end else begin
        last_code_d = code_c;
        run_d       = CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (STABLE_N == 1) begin
            state_d  = STABLE;
            rel_d    = code_c;
            change_d = 1'b1;
          end else begin
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (run_d == STABLE_CNT) begin
            state_d  = STABLE;
            rel_d    = code_c;
            change_d = 1'b1;
          end
        end
        STABLE: begin
          // With STABLE_N=1 a new code is confirmed immediately
          if (!match_c) begin
            if (STABLE_N == 1) begin
              rel_d    = code_c;
              change_d = 1'b1;
            end else begin
              state_d = ACQ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    stable_d = (state_d == STABLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_code_q <= REL_NONE;
      run_q       <= '0;
      rel_q       <= REL_NONE;
      change_q    <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_code_q <= last_code_d;
      run_q       <= run_d;
      rel_q       <= rel_d;
      change_q    <= change_d;
      stable_q    <= stable_d;
    end
  end

  assign bus.stable  = stable_q;
  assign bus.rel     = rel_q;
  assign bus.run_len = run_q;
  assign bus.change  = change_q;

`ifdef CMP_ONEHOT_CHECK_EN
  logic err_q;

  // Sticky malformed-sample flag
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if (bus.in_valid && !ok_c) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_cmp_run_monitor.sv
// Scoreboard bench for cmp_run_monitor (CNT_W=4, STABLE_N=3) with hand-computed vectors.
// The driver queues the expected outputs per cycle; a monitor pops and compares after each edge.
module tb_cmp_run_monitor;
  typedef struct {
    logic       stable;
    logic [1:0] rel;
    logic [3:0] run;
    logic       change;
    logic       err;
    string      tag;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic err_exp;
  exp_t sb[$];

  cmp_run_if #(.CNT_W(4)) bus ();

  cmp_run_monitor #(.CNT_W(4), .STABLE_N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, field, act, exp);
    end
  endtask

  // One cycle of stimulus; expected outputs for the following cycle go to the scoreboard
  task automatic drive(input logic r, input logic v, input logic e, input logic g, input logic l,
                       input logic s, input logic [1:0] rl, input logic [3:0] rn,
                       input logic ch, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.eq = e; bus.gr = g; bus.le = l;
    x.stable = s; x.rel = rl; x.run = rn; x.change = ch; x.err = err_exp; x.tag = tag;
    sb.push_back(x);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk(x.tag, "stable",  int'(bus.stable),  int'(x.stable));
        chk(x.tag, "rel",     int'(bus.rel),     int'(x.rel));
        chk(x.tag, "run_len", int'(bus.run_len), int'(x.run));
        chk(x.tag, "change",  int'(bus.change),  int'(x.change));
`ifdef CMP_ONEHOT_CHECK_EN
        chk(x.tag, "err",     int'(bus.err),     int'(x.err));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wait_cycles;
    clk = 1'b0; rst = 1'b1; err_exp = 1'b0;
    checks = 0; errors = 0;
    bus.in_valid = 1'b0; bus.eq = 1'b0; bus.gr = 1'b0; bus.le = 1'b0;

    // Reset, with a valid sample present to show reset wins
    drive(1, 1, 0, 1, 0, 0, 2'b00, 4'd0, 0, "reset0");
    drive(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, "reset1");

    // First confirmation on GT
    drive(0, 1, 0, 1, 0, 0, 2'b00, 4'd1, 0, "first_gt1");
    drive(0, 1, 0, 1, 0, 0, 2'b00, 4'd2, 0, "first_gt2");
    drive(0, 1, 0, 1, 0, 1, 2'b11, 4'd3, 1, "first_gt3");
    drive(0, 0, 0, 0, 0, 1, 2'b11, 4'd3, 0, "first_idle");

    // Saturation at 15
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 1, 0, 1, 2'b11, ((4 + i) > 15) ? 4'd15 : 4'(4 + i), 0, "sat");
    end

    // Swap GT -> LT
    drive(0, 1, 0, 0, 1, 0, 2'b11, 4'd1, 0, "swap_lt1");
    drive(0, 1, 0, 0, 1, 0, 2'b11, 4'd2, 0, "swap_lt2");
    drive(0, 1, 0, 0, 1, 1, 2'b01, 4'd3, 1, "swap_lt3");
    drive(0, 0, 0, 0, 0, 1, 2'b01, 4'd3, 0, "swap_idle");

    // EQ with valid gaps
    drive(0, 1, 1, 0, 0, 0, 2'b01, 4'd1, 0, "gap_eq1");
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, 2'b01, 4'd1, 0, "gap_hold5");
    drive(0, 1, 1, 0, 0, 0, 2'b01, 4'd2, 0, "gap_eq2");
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 1, 0, 0, 2'b01, 4'd2, 0, "gap_hold2");
    drive(0, 1, 1, 0, 0, 1, 2'b10, 4'd3, 1, "gap_eq3");
    drive(0, 0, 0, 0, 0, 1, 2'b10, 4'd3, 0, "gap_idle");

    // Malformed eq+gr from run_len=2 GT
    drive(0, 1, 0, 1, 0, 0, 2'b10, 4'd1, 0, "mal_gt1");
    drive(0, 1, 0, 1, 0, 0, 2'b10, 4'd2, 0, "mal_gt2");
`ifdef CMP_ONEHOT_CHECK_EN
    err_exp = 1'b1;
    drive(0, 1, 1, 1, 0, 0, 2'b10, 4'd2, 0, "mal_bad");
    drive(0, 0, 0, 0, 0, 0, 2'b10, 4'd2, 0, "mal_hold");
`else
    drive(0, 1, 1, 1, 0, 0, 2'b10, 4'd1, 0, "mal_as_eq");
    drive(0, 0, 0, 0, 0, 0, 2'b10, 4'd1, 0, "mal_hold");
`endif

    // Reset mid-run, then confirm GT again
    err_exp = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 2'b00, 4'd0, 0, "rst_a");
    drive(0, 1, 0, 1, 0, 0, 2'b00, 4'd1, 0, "rst_gt1");
    drive(0, 1, 0, 1, 0, 0, 2'b00, 4'd2, 0, "rst_gt2");
    drive(1, 1, 0, 1, 0, 0, 2'b00, 4'd0, 0, "rst_mid");
    drive(0, 1, 0, 1, 0, 0, 2'b00, 4'd1, 0, "post_gt1");
    drive(0, 1, 0, 1, 0, 0, 2'b00, 4'd2, 0, "post_gt2");
    drive(0, 1, 0, 1, 0, 1, 2'b11, 4'd3, 1, "post_gt3");
    drive(0, 0, 0, 0, 0, 1, 2'b11, 4'd3, 0, "post_idle");

    // All-zero flags
`ifdef CMP_ONEHOT_CHECK_EN
    err_exp = 1'b1;
    drive(0, 1, 0, 0, 0, 1, 2'b11, 4'd3, 0, "zero1");
    drive(0, 1, 0, 0, 0, 1, 2'b11, 4'd3, 0, "zero2");
`else
    drive(0, 1, 0, 0, 0, 0, 2'b11, 4'd1, 0, "zero_lt1");
    drive(0, 1, 0, 0, 0, 0, 2'b11, 4'd2, 0, "zero_lt2");
    drive(0, 1, 0, 0, 0, 1, 2'b01, 4'd3, 1, "zero_lt3");
`endif

    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmp_run_monitor.md
# cmp_run_monitor

Streaming monitor that sits directly downstream of the 4-bit magnitude comparator and consumes its `eq`/`gr`/`le` result flags one sample per valid cycle. It encodes each sample as a relation code and tracks runs of identical consecutive relations. It declares a relation "stable" after `STABLE_N` matching samples and pulses `change` whenever a newly confirmed relation is established. Optionally, it checks that the incoming flags are one-hot.

## Interface
- `CNT_W`, default 4, width of the run-length counter; the counter saturates at 2^CNT_W−1.
- `STABLE_N`, default 3, number of consecutive matching valid samples needed to confirm a relation. Legal range is 1 ≤ STABLE_N ≤ 2^CNT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the flags on `eq`/`gr`/`le` form a sample this cycle.
- `eq`  in  1  comparator equal flag.
- `gr`  in  1  comparator greater flag (a > b).
- `le`  in  1  comparator less flag (a < b).
- `stable`  out  1  the current run has reached `STABLE_N`.
- `rel`  out  2  last confirmed relation: 00 none, 01 LT, 10 EQ, 11 GT.
- `run_len`  out  CNT_W  length of the current run of identical relations, saturating.
- `change`  out  1  one-cycle pulse when a relation is newly confirmed.
- `err`  out  1  sticky flag for a malformed sample; exists only with the macro (see Configuration).

## Operation
- **Sample decode:** eq → EQ (10), gr → GT (11), le → LT (01). The handling of malformed flag patterns is given under Configuration.
- **Internal state:** `last_code` (2 bits), run counter, and an FSM with states IDLE, ACQ and STABLE.
- **Cycles with `in_valid`=0:** all state and outputs hold. `change` is forced to 0.
- **Accepted sample, code == `last_code`:** run_len ← min(run_len+1, 2^CNT_W−1).
- **Accepted sample, code ≠ `last_code`, or state is IDLE:** last_code ← code; run_len ← 1.
- **FSM, IDLE:** any accepted sample moves to ACQ. If STABLE_N=1, it moves straight to STABLE.
- **FSM, ACQ:** moves to STABLE when the updated run_len reaches STABLE_N. Otherwise it stays in ACQ.
- **FSM, STABLE:** a matching sample stays in STABLE. A differing sample moves to ACQ (run_len=1). If STABLE_N=1, a differing sample stays in STABLE with the new code.
- **Confirmation (ACQ→STABLE, or a code swap within STABLE when STABLE_N=1):**
  - `rel` ← code.
  - `change` ← 1 for exactly one cycle.
  - `change` fires even if the new code equals the previously confirmed `rel`.
- **`rel` in ACQ:** holds the last confirmed value. It reads 00 only until the first confirmation after reset.
- **`stable`:** equals (state == STABLE).
- **Saturation:** at run_len = 2^CNT_W−1, further matches leave run_len and `stable` unchanged and do not raise `change`.

## Timing
- All outputs are registered. A sample accepted in cycle n is reflected on the outputs in cycle n+1.
- With STABLE_N=3: `stable`/`change` rise the cycle after the 3rd matching valid sample. `in_valid` gaps between the samples are allowed.
- A differing sample while STABLE drops `stable` in the next cycle.
- **Reset:** while `rst` is high at a clock edge, the next cycle shows:
  - state = IDLE;
  - `stable`=0, `rel`=00, `run_len`=0, `change`=0, `err`=0;
  - `last_code`=00.
- `rst` overrides `in_valid` in the same cycle. Reset mid-run discards the run.
- There is no backpressure. Every valid cycle is consumed.

## Configuration
- **`CMP_ONEHOT_CHECK_EN` defined:**
  - A valid sample with other than exactly one of eq/gr/le set is discarded; state, `run_len`, `rel` and `change` are unaffected.
  - Such a sample sets `err`=1 in the next cycle, and `err` holds until reset.
- **`CMP_ONEHOT_CHECK_EN` not defined:**
  - The `err` port is absent.
  - Decode uses priority eq > gr > le.
  - All-zero flags decode as LT.
  - Every valid sample is accepted.

## Test plan
All scenarios use CNT_W=4, STABLE_N=3.
- **First confirmation:** reset, then 3 valid GT samples (gr=1) → cycle after the 3rd sample: stable=1, rel=11, run_len=3, change=1 for one cycle, then 0.
- **Saturation:** from STABLE GT, 20 more GT samples → run_len stops at 15; stable stays 1; change stays 0.
- **Relation swap:** from STABLE GT, send 1 LT sample → stable=0, rel=11, run_len=1. Then 2 more LT → stable=1, rel=01, change pulses once.
- **Valid gaps:** EQ, 5 idle cycles, EQ, 2 idle cycles, EQ → outputs hold during the gaps; stable=1, rel=10 one cycle after the 3rd EQ.
- **Malformed flags:** from run_len=2 GT, send eq=1,gr=1.
  - Macro defined → err=1 and stays 1; run_len stays 2.
  - Macro undefined → the sample decodes as EQ; run_len=1; stable=0.
- **Reset mid-run:** at run_len=2, assert rst for 1 cycle → next cycle all outputs are zero. Then 3 GT samples → change pulses again.
